// File: rtl/dfp_arbiter_if.sv
// rtl/dfp_arbiter_if.sv - cache-line dfp bus: cache/adaptor side is master, arbiter side is slave
interface dfp_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [ADDR_W-1:0] addr;
  logic              read;
  logic              write;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;

  // Request issuer: drives address/op/write line, receives the read line and completion
  modport master (
    output addr, read, write, wdata,
    input  rdata, resp
  );

  // Request server: sees address/op/write line, returns the read line and completion
  modport slave (
    input  addr, read, write, wdata,
    output rdata, resp
  );
endinterface

// File: rtl/dfp_arbiter.sv
// rtl/dfp_arbiter.sv - shares one cache-line memory adaptor between icache and dcache
module dfp_arbiter #(
  parameter int LINE_W     = 256,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  dfp_arbiter_if.slave  i_dfp,
  dfp_arbiter_if.slave  d_dfp,
  dfp_arbiter_if.master mem
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [SW-1:0]     starve_q, starve_d;

  logic i_req;
  logic d_req;
  logic d_wins;

  // The icache never writes, so its write/wdata lines carry nothing we use
  logic unused_ok;
  assign unused_ok = ^{i_dfp.write, i_dfp.wdata};

  assign i_req = i_dfp.read;
  assign d_req = d_dfp.read | d_dfp.write;
  // D has default priority unless I has already waited through STARVE_MAX D grants
  assign d_wins = d_req && (!i_req || (starve_q < STARVE_LIM));

  // State, latched request and starvation counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      read_q   <= read_d;
      write_q  <= write_d;
      starve_q <= starve_d;
    end
  end

  // Request selection, latching on grant, adaptor drive and response steering
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    read_d   = read_q;
    write_d  = write_q;
    starve_d = starve_q;

    mem.addr    = '0;
    mem.read    = 1'b0;
    mem.write   = 1'b0;
    mem.wdata   = '0;
    i_dfp.rdata = '0;
    i_dfp.resp  = 1'b0;
    d_dfp.rdata = '0;
    d_dfp.resp  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Adaptor sees no request here, so a response can never restart a stale op
        if (d_wins) begin
          state_d = GRANT_D;
          addr_d  = d_dfp.addr;
          write_d = d_dfp.write;
          read_d  = !d_dfp.write;
          wdata_d = d_dfp.wdata;
          if (i_req) begin
            starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end else if (i_req) begin
          state_d  = GRANT_I;
          addr_d   = i_dfp.addr;
          write_d  = 1'b0;
          read_d   = 1'b1;
          wdata_d  = '0;
          starve_d = '0;
        end
      end

      GRANT_I: begin
        mem.addr  = addr_q;
        mem.read  = read_q;
        mem.write = write_q;
        mem.wdata = wdata_q;
        if (mem.resp) begin
          i_dfp.resp  = 1'b1;
          i_dfp.rdata = mem.rdata;
          state_d     = IDLE;
        end
      end

      GRANT_D: begin
        mem.addr  = addr_q;
        mem.read  = read_q;
        mem.write = write_q;
        mem.wdata = wdata_q;
        if (mem.resp) begin
          d_dfp.resp  = 1'b1;
          d_dfp.rdata = mem.rdata;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A dcache asking for read and write together is a dcache bug; it is served as a write
  assert property (@(posedge clk) disable iff (rst) !(d_dfp.read && d_dfp.write));

  // The adaptor must only complete a transaction the arbiter actually issued
  assert property (@(posedge clk) disable iff (rst) !((state_q == IDLE) && mem.resp));

endmodule

// File: tb/tb_dfp_arbiter.sv
// tb/tb_dfp_arbiter.sv - directed self-checking bench for dfp_arbiter
module tb_dfp_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fails  = 0;

  logic [LW-1:0] line_a5;
  logic [LW-1:0] line_wb;
  logic [LW-1:0] line_d1;
  logic [LW-1:0] line_i2;
  logic [LW-1:0] line_x;

  dfp_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) ic_if ();
  dfp_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) dc_if ();
  dfp_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) mem_if ();

  dfp_arbiter #(.LINE_W(LW), .ADDR_W(AW), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .i_dfp (ic_if),
    .d_dfp (dc_if),
    .mem   (mem_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    line_a5 = {32{8'hA5}};
    line_wb = {4{64'hDEAD_BEEF_0123_4567}};
    line_d1 = {8{32'hD1D1_0001}};
    line_i2 = {8{32'h1202_0002}};

    ic_if.addr = '0; ic_if.read = 1'b0; ic_if.write = 1'b0; ic_if.wdata = '0;
    dc_if.addr = '0; dc_if.read = 1'b0; dc_if.write = 1'b0; dc_if.wdata = '0;
    mem_if.rdata = '0; mem_if.resp = 1'b0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;

    check_eq("rst_mem_read",  mem_if.read,  1'b0);
    check_eq("rst_mem_write", mem_if.write, 1'b0);
    check_eq("rst_mem_addr",  mem_if.addr,  '0);
    check_eq("rst_mem_wdata", mem_if.wdata, '0);
    check_eq("rst_i_resp",    ic_if.resp,   1'b0);
    check_eq("rst_d_resp",    dc_if.resp,   1'b0);

    // I read alone
    ic_if.addr = 32'h0000_1000;
    ic_if.read = 1'b1;
    tick();
    check_eq("i_rd_mem_read",  mem_if.read,  1'b1);
    check_eq("i_rd_mem_write", mem_if.write, 1'b0);
    check_eq("i_rd_mem_addr",  mem_if.addr,  32'h0000_1000);
    tick();
    check_eq("i_rd_hold_read", mem_if.read, 1'b1);
    mem_if.rdata = line_a5;
    mem_if.resp  = 1'b1;
    #1;
    check_eq("i_rd_resp",    ic_if.resp,  1'b1);
    check_eq("i_rd_rdata",   ic_if.rdata, line_a5);
    check_eq("i_rd_d_resp",  dc_if.resp,  1'b0);
    check_eq("i_rd_d_rdata", dc_if.rdata, '0);
    tick();
    mem_if.resp  = 1'b0;
    mem_if.rdata = '0;
    ic_if.read   = 1'b0;
    #1;
    check_eq("i_rd_after_read", mem_if.read, 1'b0);
    check_eq("i_rd_after_resp", ic_if.resp,  1'b0);

    // D write, wdata held across the burst even if the dcache changes its line
    dc_if.addr  = 32'h0000_2000;
    dc_if.write = 1'b1;
    dc_if.wdata = line_wb;
    tick();
    check_eq("d_wr_mem_write", mem_if.write, 1'b1);
    check_eq("d_wr_mem_read",  mem_if.read,  1'b0);
    check_eq("d_wr_mem_addr",  mem_if.addr,  32'h0000_2000);
    dc_if.wdata = '0;
    for (int b = 0; b < 4; b++) begin
      #1;
      check_eq("d_wr_wdata_hold", mem_if.wdata, line_wb);
      tick();
    end
    mem_if.resp = 1'b1;
    #1;
    check_eq("d_wr_resp",   dc_if.resp, 1'b1);
    check_eq("d_wr_i_resp", ic_if.resp, 1'b0);
    tick();
    mem_if.resp = 1'b0;
    dc_if.write = 1'b0;
    #1;
    check_eq("d_wr_after_write", mem_if.write, 1'b0);
    check_eq("d_wr_single_resp", dc_if.resp,   1'b0);

    // Simultaneous I and D reads: D first, addr held despite mid-grant changes
    ic_if.addr = 32'h0000_1000;
    ic_if.read = 1'b1;
    dc_if.addr = 32'h0000_3000;
    dc_if.read = 1'b1;
    tick();
    check_eq("both_first_addr", mem_if.addr, 32'h0000_3000);
    check_eq("both_first_read", mem_if.read, 1'b1);
    dc_if.addr = 32'h0000_4000;
    tick();
    check_eq("midgrant_addr", mem_if.addr, 32'h0000_3000);
    mem_if.rdata = line_d1;
    mem_if.resp  = 1'b1;
    #1;
    check_eq("both_d_resp",    dc_if.resp,  1'b1);
    check_eq("both_d_rdata",   dc_if.rdata, line_d1);
    check_eq("both_i_resp0",   ic_if.resp,  1'b0);
    check_eq("both_i_rdata0",  ic_if.rdata, '0);
    tick();
    mem_if.resp  = 1'b0;
    mem_if.rdata = '0;
    dc_if.read   = 1'b0;
    #1;
    check_eq("both_gap_read", mem_if.read, 1'b0);
    tick();
    check_eq("both_second_addr", mem_if.addr, 32'h0000_1000);
    check_eq("both_second_read", mem_if.read, 1'b1);
    mem_if.rdata = line_i2;
    mem_if.resp  = 1'b1;
    #1;
    check_eq("both_i_resp",  ic_if.resp,  1'b1);
    check_eq("both_i_rdata", ic_if.rdata, line_i2);
    check_eq("both_d_resp0", dc_if.resp,  1'b0);
    tick();
    mem_if.resp  = 1'b0;
    mem_if.rdata = '0;
    ic_if.read   = 1'b0;
    #1;

    // Starvation guard: four D grants, then I
    ic_if.addr = 32'h0000_1000;
    ic_if.read = 1'b1;
    dc_if.addr = 32'h0000_5000;
    dc_if.read = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      check_eq("starve_grant_addr", mem_if.addr, (g < 4) ? 32'h0000_5000 : 32'h0000_1000);
      mem_if.resp = 1'b1;
      #1;
      check_eq("starve_i_resp", ic_if.resp, (g < 4) ? 1'b0 : 1'b1);
      check_eq("starve_d_resp", dc_if.resp, (g < 4) ? 1'b1 : 1'b0);
      tick();
      mem_if.resp = 1'b0;
      #1;
      check_eq("starve_gap_read", mem_if.read, 1'b0);
    end
    check_eq("starve_cnt_clear", dut.starve_q, 3'd0);

    // After the counter clears, D wins again; reset that grant before mem_resp
    tick();
    check_eq("post_starve_addr", mem_if.addr, 32'h0000_5000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ic_if.read = 1'b0;
    dc_if.read = 1'b0;
    #1;
    check_eq("abort_mem_read",  mem_if.read,  1'b0);
    check_eq("abort_mem_write", mem_if.write, 1'b0);
    check_eq("abort_mem_addr",  mem_if.addr,  '0);
    check_eq("abort_d_resp",    dc_if.resp,   1'b0);
    check_eq("abort_i_resp",    ic_if.resp,   1'b0);

    // Fresh I request after the abort
    ic_if.addr = 32'h0000_6000;
    ic_if.read = 1'b1;
    tick();
    check_eq("fresh_addr", mem_if.addr, 32'h0000_6000);
    check_eq("fresh_read", mem_if.read, 1'b1);
    line_x = line_a5 ^ line_i2;
    mem_if.rdata = line_x;
    mem_if.resp  = 1'b1;
    #1;
    check_eq("fresh_i_resp",  ic_if.resp,  1'b1);
    check_eq("fresh_i_rdata", ic_if.rdata, line_x);
    tick();
    mem_if.resp  = 1'b0;
    mem_if.rdata = '0;
    ic_if.read   = 1'b0;
    #1;
    check_eq("fresh_after_read", mem_if.read, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
